hmm_obs_gen: RTL and testbench
==============================

HMM_OBS_GEN -- requirements
Module: hmm_obs_gen

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low: clk (rising edge), rst_n.
REQ-002 SHALL have parameter N, default 8, meaning the maximum number of emitted symbols per sequence.
REQ-003 clk  input  1  system clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  level request to begin a sequence, sampled in IDLE only.
REQ-006 length  input  4  requested symbol count, latched at start.
REQ-007 seed  input  16  LFSR seed, latched at start.
REQ-008 cdf_c  input  18  initial-state thresholds {th1[17:9], th0[8:0]}, unsigned.
REQ-009 cdf_a  input  54  transition thresholds; row i (previous state) = bits [18i+17:18i] as {th1, th0}.
REQ-010 cdf_b  input  54  emission thresholds; row j (current state) = bits [18j+17:18j] as {th1, th0}.
REQ-011 obs_out  output  2  emitted observation symbol.
REQ-012 state_out  output  2  hidden state that produced obs_out, for scoreboarding.
REQ-013 obs_valid  output  1  obs_out/state_out/obs_last valid.
REQ-014 obs_ready  input  1  downstream accepts the symbol.
REQ-015 obs_last  output  1  high with the final symbol of the sequence.
REQ-016 busy  output  1  high in every state except IDLE and DONE.
REQ-017 done  output  1  sequence complete.

Function
REQ-018 States: IDLE, SDRAW, EDRAW, HOLD, DONE.
REQ-019 Draw rule: r = lfsr[7:0] zero-extended to 9 bits; result 0 if r < th0, else 1 if r < th1, else 2; every draw advances the LFSR exactly one step in the same edge.
REQ-020 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, new bit[0] = l[15]^l[13]^l[12]^l[10]; a seed of 0 loads 16'hACE1.
REQ-021 IDLE: done=0; on start=1, latch seed and effective length, and set t=0; if effective length = 0, go to DONE; otherwise go to SDRAW.
REQ-022 Effective length = length when length is in 0..N; length > N is clamped to N.
REQ-023 SDRAW: draw the state from cdf_c when t=0, else from the cdf_a row of the previous state; go to EDRAW.
REQ-024 EDRAW: draw the symbol from the cdf_b row of the current state; load obs_out/state_out; assert obs_valid; assert obs_last iff t = length-1; go to HOLD.
REQ-025 HOLD: obs_out, state_out, obs_last and obs_valid are held stable while obs_ready=0.
REQ-026 HOLD on obs_ready=1: deassert obs_valid and obs_last at that edge; if obs_last, go to DONE with done=1; else t=t+1 and go to SDRAW.
REQ-027 Latency: the start edge is edge k; obs_valid rises after edge k+2; minimum 3 cycles per symbol.
REQ-028 DONE: done=1 held; go to IDLE when start=0; start held high does not restart.
REQ-029 start outside IDLE is ignored; cdf/seed/length changes after the start edge have no effect except cdf_a/cdf_b, which are sampled live at each draw.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, obs_out=0, state_out=0, obs_valid=0, obs_last=0, busy=0, done=0, t=0, lfsr=16'hACE1, regardless of the current state; mid-sequence reset discards the sequence.

Verification
REQ-031 Deterministic ring: cdf_c={256,256}; cdf_a rows {0:{256,0}, 1:{0,0}, 2:{256,256}}; cdf_b rows {0:{256,256}, 1:{256,0}, 2:{0,0}}; length=5; obs_ready=1 -> states/obs 0,1,2,0,1; obs_last only on the 5th symbol; done rises one edge after that handshake.
REQ-032 Backpressure: same setup, obs_ready=0 for 4 cycles while the 2nd symbol is valid -> obs_out=1, state_out=1, obs_valid=1 stable throughout; no symbol lost or duplicated.
REQ-033 Length bounds: length=0 -> DONE after one edge, obs_valid never high; length=12 -> exactly 8 symbols emitted.
REQ-034 Randomness: all thresholds {128,192}, seed=0x0001, length=8 -> sequence matches the bit-exact LFSR reference model; seed=0 gives output identical to seed=0xACE1.
REQ-035 Reset mid-sequence: rst_n low during the 3rd HOLD -> all outputs 0 the same cycle; the next start reproduces the full sequence from symbol 1.
REQ-036 start held high through DONE -> no second sequence until start drops for at least one cycle.

Source files
------------

// File: rtl/hmm_obs_gen_if.sv
// rtl/hmm_obs_gen_if.sv - request/config and symbol-stream bundle for hmm_obs_gen
// master: sequence requester / symbol consumer (drives start, length, seed, cdf_*, obs_ready)
// slave : the generator (drives obs_out, state_out, obs_valid, obs_last, busy, done)
interface hmm_obs_gen_if;
    logic        start;
    logic [3:0]  length;
    logic [15:0] seed;
    logic [17:0] cdf_c;
    logic [53:0] cdf_a;
    logic [53:0] cdf_b;
    logic [1:0]  obs_out;
    logic [1:0]  state_out;
    logic        obs_valid;
    logic        obs_ready;
    logic        obs_last;
    logic        busy;
    logic        done;

    modport master (
        output start, length, seed, cdf_c, cdf_a, cdf_b, obs_ready,
        input  obs_out, state_out, obs_valid, obs_last, busy, done
    );

    modport slave (
        input  start, length, seed, cdf_c, cdf_a, cdf_b, obs_ready,
        output obs_out, state_out, obs_valid, obs_last, busy, done
    );
endinterface

// File: rtl/hmm_obs_gen.sv
// rtl/hmm_obs_gen.sv - 3-state/3-symbol hidden Markov model observation generator
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave side of hmm_obs_gen_if: start/length/seed/cdf_c/cdf_a/cdf_b in,
//            obs_out/state_out/obs_valid/obs_last out with obs_ready back-pressure,
//            busy/done status out
// Each symbol costs an SDRAW (hidden state) and EDRAW (emission) draw from a
// 16-bit Fibonacci LFSR, then waits in HOLD for the consumer.
module hmm_obs_gen #(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    hmm_obs_gen_if.slave  bus
);
    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam logic [3:0]  N_L       = 4'(N);

    typedef enum logic [2:0] {
        S_IDLE, S_SDRAW, S_EDRAW, S_HOLD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  t_q, t_d;
    logic [1:0]  cur_q, cur_d;
    logic [1:0]  obs_q, obs_d;
    logic [1:0]  st_q, st_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;

    logic [15:0] lfsr_next;
    logic [3:0]  eff_len;

    // Threshold draw: r = low LFSR byte; below th0 -> 0, below th1 -> 1, else 2.
    function automatic logic [1:0] draw(input logic [7:0] lb, input logic [17:0] row);
        logic [8:0] r;
        r = {1'b0, lb};
        if (r < row[8:0])
            return 2'd0;
        else if (r < row[17:9])
            return 2'd1;
        return 2'd2;
    endfunction

    // Row 3 cannot occur (states are 0..2); it aliases row 2.
    function automatic logic [17:0] row_sel(input logic [53:0] rows, input logic [1:0] i);
        case (i)
            2'd0:    return rows[17:0];
            2'd1:    return rows[35:18];
            default: return rows[53:36];
        endcase
    endfunction

    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign eff_len   = (bus.length > N_L) ? N_L : bus.length;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        len_d   = len_q;
        t_d     = t_q;
        cur_d   = cur_q;
        obs_d   = obs_q;
        st_d    = st_q;
        valid_d = valid_q;
        last_d  = last_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    lfsr_d  = (bus.seed == 16'd0) ? LFSR_INIT : bus.seed;
                    len_d   = eff_len;
                    t_d     = 4'd0;
                    state_d = (eff_len == 4'd0) ? S_DONE : S_SDRAW;
                end
            end
            S_SDRAW: begin
                // First symbol uses the initial distribution; later ones the
                // transition row of the previous hidden state (cur_q).
                cur_d   = draw(lfsr_q[7:0], (t_q == 4'd0) ? bus.cdf_c : row_sel(bus.cdf_a, cur_q));
                lfsr_d  = lfsr_next;
                state_d = S_EDRAW;
            end
            S_EDRAW: begin
                obs_d   = draw(lfsr_q[7:0], row_sel(bus.cdf_b, cur_q));
                st_d    = cur_q;
                valid_d = 1'b1;
                last_d  = (t_q == len_q - 4'd1);
                lfsr_d  = lfsr_next;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (bus.obs_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                    end else begin
                        t_d     = t_q + 4'd1;
                        state_d = S_SDRAW;
                    end
                end
            end
            S_DONE: begin
                // Requires start to drop before another sequence can begin.
                if (!bus.start)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_INIT;
            len_q   <= 4'd0;
            t_q     <= 4'd0;
            cur_q   <= 2'd0;
            obs_q   <= 2'd0;
            st_q    <= 2'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            len_q   <= len_d;
            t_q     <= t_d;
            cur_q   <= cur_d;
            obs_q   <= obs_d;
            st_q    <= st_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.obs_out   = obs_q;
    assign bus.state_out = st_q;
    assign bus.obs_valid = valid_q;
    assign bus.obs_last  = last_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_hmm_obs_gen.sv
// tb/tb_hmm_obs_gen.sv - directed self-checking bench for hmm_obs_gen
module tb_hmm_obs_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hmm_obs_gen_if bus();
    hmm_obs_gen #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [17:0] RING_C  = {9'd256, 9'd256};
    localparam logic [53:0] RING_A  = {9'd256, 9'd256, 9'd0, 9'd0, 9'd256, 9'd0};
    localparam logic [53:0] RING_B  = {9'd0, 9'd0, 9'd256, 9'd0, 9'd256, 9'd256};
    localparam logic [17:0] RND_ROW = {9'd192, 9'd128};

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] got_obs [16];
    logic [1:0] got_st  [16];
    logic       got_last[16];
    int n, last_cyc, done_cyc;

    logic [1:0] exp_obs[16];
    logic [1:0] exp_st [16];
    int exp_n;

    function automatic logic [1:0] mdraw(input logic [15:0] l, input logic [17:0] row);
        logic [8:0] r;
        r = {1'b0, l[7:0]};
        if (r < row[8:0]) return 2'd0;
        if (r < row[17:9]) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [15:0] mstep(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic build_model(input logic [15:0] sd, input int len,
                               input logic [17:0] c, input logic [53:0] a, input logic [53:0] b);
        logic [15:0] l;
        logic [17:0] row;
        logic [1:0]  s, prev;
        l = (sd == 16'd0) ? 16'hACE1 : sd;
        exp_n = (len > 8) ? 8 : len;
        prev = 2'd0;
        for (int i = 0; i < exp_n; i++) begin
            row = (i == 0) ? c : a[18*int'(prev) +: 18];
            s = mdraw(l, row);
            l = mstep(l);
            exp_obs[i] = mdraw(l, b[18*int'(s) +: 18]);
            l = mstep(l);
            exp_st[i] = s;
            prev = s;
        end
    endtask

    task automatic setup(input logic [3:0] len, input logic [15:0] sd,
                         input logic [17:0] c, input logic [53:0] a, input logic [53:0] b);
        bus.length = len; bus.seed = sd;
        bus.cdf_c = c; bus.cdf_a = a; bus.cdf_b = b;
        bus.obs_ready = 1'b1;
    endtask

    task automatic kick();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Records every handshake seen at negedges until done or the budget runs out.
    task automatic collect(input int budget);
        n = 0; last_cyc = -1; done_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            if (bus.obs_valid && bus.obs_ready) begin
                if (n < 16) begin
                    got_obs[n] = bus.obs_out; got_st[n] = bus.state_out; got_last[n] = bus.obs_last;
                end
                if (bus.obs_last) last_cyc = c;
                n++;
            end
            if (bus.done) begin done_cyc = c; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        setup(4'd0, 16'd0, RING_C, RING_A, RING_B);
        @(negedge clk); @(negedge clk);
        vectors++; if (bus.obs_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", bus.obs_valid); end
        vectors++; if (bus.obs_out !== 2'd0) begin miscompares++; $display("FAIL reset_obs: got %0d expected 0", bus.obs_out); end
        vectors++; if (bus.state_out !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.state_out); end
        vectors++; if (bus.obs_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b expected 0", bus.obs_last); end
        vectors++; if ({bus.busy, bus.done} !== 2'b00) begin miscompares++; $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ring();
        int ring[5] = '{0, 1, 2, 0, 1};
        setup(4'd5, 16'd1, RING_C, RING_A, RING_B);
        kick();
        vectors++; if ({bus.busy, bus.obs_valid} !== 2'b10) begin miscompares++; $display("FAIL ring_lat_k: got busy/valid %b expected 10", {bus.busy, bus.obs_valid}); end
        @(negedge clk);
        vectors++; if (bus.obs_valid !== 1'b0) begin miscompares++; $display("FAIL ring_lat_k1: got %b expected 0", bus.obs_valid); end
        @(negedge clk);
        vectors++; if (bus.obs_valid !== 1'b1) begin miscompares++; $display("FAIL ring_lat_k2: got %b expected 1", bus.obs_valid); end
        collect(200);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL ring_count: got %0d expected 5", n); end
        for (int i = 0; i < 5 && i < n; i++) begin
            vectors++;
            if (got_obs[i] !== 2'(ring[i]) || got_st[i] !== 2'(ring[i]) || got_last[i] !== (i == 4)) begin
                miscompares++;
                $display("FAIL ring_sym[%0d]: got obs %0d state %0d last %b expected %0d %0d %b",
                         i, got_obs[i], got_st[i], got_last[i], ring[i], ring[i], i == 4);
            end
        end
        vectors++; if (done_cyc !== last_cyc + 1 || done_cyc < 0) begin miscompares++; $display("FAIL ring_done_timing: got done at %0d last at %0d expected one apart", done_cyc, last_cyc); end
        @(negedge clk);
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL ring_done_clear: got %b expected 0", bus.done); end
    endtask

    task automatic test_backpressure();
        int ok;
        logic [1:0] rest[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
        setup(4'd5, 16'd1, RING_C, RING_A, RING_B);
        kick();
        for (int c = 0; c < 10 && !bus.obs_valid; c++) @(negedge clk);
        vectors++; if (bus.obs_valid !== 1'b1 || bus.obs_out !== 2'd0) begin miscompares++; $display("FAIL bp_first: got valid %b obs %0d expected 1 0", bus.obs_valid, bus.obs_out); end
        @(negedge clk);
        bus.obs_ready = 1'b0;
        for (int c = 0; c < 10 && !bus.obs_valid; c++) @(negedge clk);
        ok = 1;
        for (int c = 0; c < 4; c++) begin
            if (bus.obs_valid !== 1'b1 || bus.obs_out !== 2'd1 || bus.state_out !== 2'd1 || bus.obs_last !== 1'b0) ok = 0;
            @(negedge clk);
        end
        vectors++; if (ok != 1 || bus.obs_valid !== 1'b1) begin miscompares++; $display("FAIL bp_stable: got obs %0d state %0d valid %b expected 1 1 1 throughout", bus.obs_out, bus.state_out, bus.obs_valid); end
        bus.obs_ready = 1'b1;
        collect(200);
        vectors++; if (n !== 4) begin miscompares++; $display("FAIL bp_count: got %0d expected 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            vectors++;
            if (got_obs[i] !== rest[i] || got_st[i] !== rest[i]) begin
                miscompares++; $display("FAIL bp_sym[%0d]: got %0d/%0d expected %0d", i, got_obs[i], got_st[i], rest[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_length_zero();
        int vcnt = 0;
        setup(4'd0, 16'd1, RING_C, RING_A, RING_B);
        kick();
        vectors++; if ({bus.done, bus.busy, bus.obs_valid} !== 3'b100) begin miscompares++; $display("FAIL len0_done: got done/busy/valid %b expected 100", {bus.done, bus.busy, bus.obs_valid}); end
        for (int c = 0; c < 4; c++) begin
            if (bus.obs_valid) vcnt++;
            @(negedge clk);
        end
        vectors++; if (vcnt != 0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL len0_idle: got valid count %0d done %b expected 0 0", vcnt, bus.done); end
    endtask

    task automatic test_length_clamp();
        setup(4'd12, 16'd1, RING_C, RING_A, RING_B);
        kick();
        collect(400);
        vectors++; if (n !== 8) begin miscompares++; $display("FAIL clamp_count: got %0d expected 8", n); end
        for (int i = 0; i < 8 && i < n; i++) begin
            vectors++;
            if (got_obs[i] !== 2'(i % 3) || got_st[i] !== 2'(i % 3) || got_last[i] !== (i == 7)) begin
                miscompares++; $display("FAIL clamp_sym[%0d]: got %0d/%0d last %b expected %0d last %b", i, got_obs[i], got_st[i], got_last[i], i % 3, i == 7);
            end
        end
        @(negedge clk);
    endtask

    task automatic run_random(input logic [15:0] sd, input string tag);
        setup(4'd8, sd, RND_ROW, {3{RND_ROW}}, {3{RND_ROW}});
        kick();
        collect(300);
        vectors++; if (n !== exp_n) begin miscompares++; $display("FAIL %s_count: got %0d expected %0d", tag, n, exp_n); end
        for (int i = 0; i < exp_n && i < n; i++) begin
            vectors++;
            if (got_obs[i] !== exp_obs[i] || got_st[i] !== exp_st[i]) begin
                miscompares++; $display("FAIL %s_sym[%0d]: got obs %0d state %0d expected %0d %0d", tag, i, got_obs[i], got_st[i], exp_obs[i], exp_st[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        build_model(16'h0001, 8, RND_ROW, {3{RND_ROW}}, {3{RND_ROW}});
        run_random(16'h0001, "rnd_seed1");
        build_model(16'hACE1, 8, RND_ROW, {3{RND_ROW}}, {3{RND_ROW}});
        run_random(16'h0000, "rnd_seed0");
        run_random(16'hACE1, "rnd_seedace1");
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int hit = 0;
        build_model(16'h0001, 8, RND_ROW, {3{RND_ROW}}, {3{RND_ROW}});
        setup(4'd8, 16'h0001, RND_ROW, {3{RND_ROW}}, {3{RND_ROW}});
        kick();
        for (int c = 0; c < 100; c++) begin
            if (bus.obs_valid) begin
                if (k < 2) k++;
                else begin
                    bus.obs_ready = 1'b0;
                    rst_n = 1'b0;
                    #1;
                    hit = 1;
                    break;
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (hit != 1 || {bus.obs_valid, bus.obs_out, bus.state_out, bus.obs_last, bus.busy, bus.done} !== 8'd0) begin
            miscompares++; $display("FAIL midreset_outputs: got hit %0d outs %b expected 1 00000000", hit,
                                    {bus.obs_valid, bus.obs_out, bus.state_out, bus.obs_last, bus.busy, bus.done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.obs_ready = 1'b1;
        @(negedge clk);
        run_random(16'h0001, "midreset_rerun");
    endtask

    task automatic test_start_held();
        int bad = 0;
        setup(4'd5, 16'd1, RING_C, RING_A, RING_B);
        bus.start = 1'b1;
        @(negedge clk);
        collect(200);
        vectors++; if (n !== 5) begin miscompares++; $display("FAIL held_count: got %0d expected 5", n); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done !== 1'b1 || bus.obs_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL held_no_restart: got %0d bad cycles expected 0", bad); end
        bus.start = 1'b0;
        @(negedge clk);
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL held_release: got done %b expected 0", bus.done); end
        kick();
        collect(200);
        vectors++; if (n !== 5 || got_st[2] !== 2'd2) begin miscompares++; $display("FAIL held_restart: got %0d symbols state2 %0d expected 5 2", n, got_st[2]); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_ring();
        test_backpressure();
        test_length_zero();
        test_length_clamp();
        test_random();
        test_reset_mid();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
